// File: rtl/led_pio_blink.sv
// Avalon-MM output PIO for board LEDs with atomic set/clear and per-bit
// hardware blink driven by a programmable reload prescaler.
module led_pio_blink #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    PRESCALE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = PRESCALE_WIDTH'(1);

    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     blink_en_q, blink_en_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] counter_q, counter_d;
    logic                      phase_q, phase_d;

    logic                      wr;
    logic [DATA_WIDTH-1:0]     wdata_led;
    logic [PRESCALE_WIDTH-1:0] wdata_pre;
    logic                      unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign wdata_led = writedata[DATA_WIDTH-1:0];
    assign wdata_pre = writedata[PRESCALE_WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // NOTE: every next-state value gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        prescale_d = prescale_q;
        counter_d  = counter_q;
        phase_d    = phase_q;

        if (wr) begin
            case (address)
                ADDR_DATA:     data_d     = wdata_led;
                ADDR_BLINK_EN: blink_en_d = wdata_led;
                ADDR_OUTSET:   data_d     = data_q | wdata_led;
                ADDR_OUTCLEAR: data_d     = data_q & ~wdata_led;
                default:       ;
            endcase
        end

        // A PRESCALE write restarts the blink and wins over the reload tick.
        if (wr && (address == ADDR_PRESCALE)) begin
            prescale_d = wdata_pre;
            counter_d  = wdata_pre;
            phase_d    = 1'b1;
        end else if (prescale_q == '0) begin
            counter_d  = '0;
            phase_d    = 1'b1;
        end else if (counter_q == '0) begin
            counter_d  = prescale_q;
            phase_d    = ~phase_q;
        end else begin
            counter_d  = counter_q - CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // sample their next-state values from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            prescale_q <= '0;
            counter_q  <= '0;
            phase_q    <= 1'b1;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            prescale_q <= prescale_d;
            counter_q  <= counter_d;
            phase_q    <= phase_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_q);
            ADDR_BLINK_EN: readdata = 32'(blink_en_q);
            ADDR_PRESCALE: readdata = 32'(prescale_q);
            ADDR_STATUS:   readdata = {31'b0, phase_q};
            default:       readdata = '0;
        endcase
    end

    // Blinking bits are gated by the phase; non-blinking bits follow DATA.
    assign out_port = data_q & (~blink_en_q | {DATA_WIDTH{phase_q}});

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed bench for led_pio_blink: register map, set/clear, blink timing,
// prescaler restart priority and asynchronous reset.
module tb_led_pio_blink;

    localparam int         DW  = 8;
    localparam logic [7:0] RV  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [DW-1:0] out_port;

    int checks = 0;
    int errors = 0;

    led_pio_blink #(
        .DATA_WIDTH    (DW),
        .RESET_VALUE   (RV),
        .PRESCALE_WIDTH(24)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one write across a single rising edge; returns 1 ns after it.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #22;
        reset_n = 1'b1;
        #1;

        check("rst_out", 32'(out_port), 32'h0000_00A5);
        bus_read(3'd0, rd); check("rst_data", rd, 32'h0000_00A5);
        bus_read(3'd3, rd); check("rst_status", rd, 32'h0000_0001);
        bus_read(3'd1, rd); check("rst_blink_en", rd, 32'h0);
        bus_read(3'd2, rd); check("rst_prescale", rd, 32'h0);

        bus_write(3'd0, 32'hFFFF_FF3C);
        check("data_out", 32'(out_port), 32'h3C);
        bus_read(3'd0, rd); check("data_rd", rd, 32'h0000_003C);
        bus_write(3'd4, 32'h0000_0003);
        check("outset_out", 32'(out_port), 32'h3F);
        bus_read(3'd0, rd); check("outset_rd", rd, 32'h0000_003F);
        bus_write(3'd5, 32'h0000_0030);
        check("outclr_out", 32'(out_port), 32'h0F);
        bus_read(3'd0, rd); check("outclr_rd", rd, 32'h0000_000F);

        bus_write(3'd3, 32'h0000_0000);
        bus_write(3'd6, 32'h0000_00FF);
        bus_write(3'd7, 32'h0000_00FF);
        bus_read(3'd0, rd); check("reserved_wr", rd, 32'h0000_000F);
        bus_read(3'd3, rd); check("status_ro", rd, 32'h1);
        bus_read(3'd4, rd); check("rd_outset", rd, 32'h0);
        bus_read(3'd5, rd); check("rd_outclr", rd, 32'h0);
        bus_read(3'd6, rd); check("rd_res6", rd, 32'h0);

        bus_write(3'd0, 32'h0000_00FF);
        bus_write(3'd1, 32'hFFFF_FF0F);
        bus_read(3'd1, rd); check("blink_en_rd", rd, 32'h0000_000F);
        bus_write(3'd2, 32'hFF00_0003);
        bus_read(3'd2, rd); check("prescale_rd", rd, 32'h0000_0003);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("blink3_c%0d", i), 32'(out_port),
                  ((i / 4) % 2 == 0) ? 32'hFF : 32'hF0);
            bus_read(3'd3, rd);
            check($sformatf("blink3_ph%0d", i), rd,
                  ((i / 4) % 2 == 0) ? 32'h1 : 32'h0);
            step();
        end

        bus_write(3'd2, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stop_out%0d", i), 32'(out_port), 32'hFF);
            step();
        end
        bus_read(3'd3, rd); check("stop_status", rd, 32'h1);

        // Restart with PRESCALE=3; counter reaches 0 three edges later.
        bus_write(3'd2, 32'h3);
        step(); step(); step();
        check("pre_restart", 32'(out_port), 32'hFF);
        bus_write(3'd2, 32'h5);
        bus_read(3'd2, rd); check("restart_rd", rd, 32'h5);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("restart_hold%0d", i), 32'(out_port), 32'hFF);
            step();
        end
        check("restart_toggle", 32'(out_port), 32'hF0);

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out_port), 32'hA5);
        bus_read(3'd1, rd); check("async_rst_blink", rd, 32'h0);
        bus_read(3'd2, rd); check("async_rst_pre", rd, 32'h0);
        bus_read(3'd3, rd); check("async_rst_phase", rd, 32'h1);
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        @(negedge clk);
        address    = 3'd0;
        writedata  = 32'h0000_0000;
        chipselect = 1'b0;
        write_n    = 1'b0;
        step();
        write_n    = 1'b1;
        check("nocs_out", 32'(out_port), 32'hA5);
        bus_read(3'd0, rd); check("nocs_rd", rd, 32'h0000_00A5);
        for (int i = 0; i < 4; i++) step();
        check("post_rst_steady", 32'(out_port), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
